// File: rtl/espacc_dma_read_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : espacc_dma_read_arbiter_if
// Purpose  : Bundles the requester-side read handshakes and the single
//            ESP DMA read port (ctrl + data channel) shared by the arbiter.
// Ports    : requester side  - req_ctrl_* (packed per requester), req_chnl_*
//            DMA side        - dma_read_ctrl_*, dma_read_chnl_*
// Modports : master - arbiter view (drives DMA requests and requester acks)
//            slave  - environment view (requesters plus DMA engine)
// Revision : 1.0 - initial release
// ============================================================================
interface espacc_dma_read_arbiter_if #(
  parameter int NREQ          = 2,
  parameter int DMA_BUS_WIDTH = 32,
  parameter int LEN_W         = 32
);
  // Requester side; requester i occupies slice [i*LEN_W +: LEN_W] / [i*3 +: 3]
  logic [NREQ-1:0]          req_ctrl_valid;
  logic [NREQ-1:0]          req_ctrl_ready;
  logic [NREQ*LEN_W-1:0]    req_ctrl_index;
  logic [NREQ*LEN_W-1:0]    req_ctrl_length;
  logic [NREQ*3-1:0]        req_ctrl_size;
  logic [NREQ-1:0]          req_chnl_valid;
  logic [NREQ-1:0]          req_chnl_ready;
  logic [DMA_BUS_WIDTH-1:0] req_chnl_data;

  // DMA read port
  logic                     dma_read_ctrl_valid;
  logic                     dma_read_ctrl_ready;
  logic [LEN_W-1:0]         dma_read_ctrl_data_index;
  logic [LEN_W-1:0]         dma_read_ctrl_data_length;
  logic [2:0]               dma_read_ctrl_data_size;
  logic                     dma_read_chnl_valid;
  logic                     dma_read_chnl_ready;
  logic [DMA_BUS_WIDTH-1:0] dma_read_chnl_data;

  modport master (
    input  req_ctrl_valid, req_ctrl_index, req_ctrl_length, req_ctrl_size,
    input  req_chnl_ready,
    output req_ctrl_ready, req_chnl_valid, req_chnl_data,
    output dma_read_ctrl_valid, dma_read_ctrl_data_index,
    output dma_read_ctrl_data_length, dma_read_ctrl_data_size,
    output dma_read_chnl_ready,
    input  dma_read_ctrl_ready, dma_read_chnl_valid, dma_read_chnl_data
  );

  modport slave (
    output req_ctrl_valid, req_ctrl_index, req_ctrl_length, req_ctrl_size,
    output req_chnl_ready,
    input  req_ctrl_ready, req_chnl_valid, req_chnl_data,
    input  dma_read_ctrl_valid, dma_read_ctrl_data_index,
    input  dma_read_ctrl_data_length, dma_read_ctrl_data_size,
    input  dma_read_chnl_ready,
    output dma_read_ctrl_ready, dma_read_chnl_valid, dma_read_chnl_data
  );
endinterface
`default_nettype wire

// File: rtl/espacc_dma_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : espacc_dma_read_arbiter
// Purpose  : Shares one ESP DMA read port between NREQ requesters. One whole
//            transaction (ctrl handshake followed by exactly `length` beats)
//            is granted at a time; at least one IDLE cycle separates grants.
// Ports    : clk, rst (asynchronous, active low)
//            bus   - espacc_dma_read_arbiter_if.master (requesters + DMA)
//            owner - index of the current grant holder (debug)
//            busy  - high whenever a transaction is in flight
// Config   : DMA_RD_ARB_FIXED_PRIO_EN - when defined, the lowest-index valid
//            requester always wins and rr_ptr stays 0; otherwise round-robin.
// Revision : 1.0 - initial release
// ============================================================================
module espacc_dma_read_arbiter #(
  parameter int NREQ          = 2,
  parameter int DMA_BUS_WIDTH = 32,
  parameter int LEN_W         = 32
) (
  input  logic                             clk,
  input  logic                             rst,
  espacc_dma_read_arbiter_if.master        bus,
  output logic [2:0]                       owner,
  output logic                             busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CTRL = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  localparam logic [2:0] LAST_REQ = 3'(NREQ - 1);

  state_t           state_q;
  logic [2:0]       rr_ptr_q;
  logic [2:0]       owner_q;
  logic [LEN_W-1:0] cnt_q;
  logic [LEN_W-1:0] index_q;
  logic [LEN_W-1:0] length_q;
  logic [2:0]       size_q;
  logic             ctrl_valid_q;
  logic             busy_q;

  logic             grant_vld_d;
  logic [2:0]       grant_d;
  logic [LEN_W-1:0] index_d;
  logic [LEN_W-1:0] length_d;
  logic [2:0]       size_d;
  logic [2:0]       next_ptr_d;
  int               cand_d;
  logic             owner_chnl_ready;
  logic             beat;

  // Winner search: walk upward from rr_ptr with wrap and take the first
  // valid requester. In fixed-priority builds rr_ptr is pinned at 0, so the
  // same walk degenerates to lowest-index-wins.
  always_comb begin
    grant_vld_d = 1'b0;
    grant_d     = 3'd0;
    cand_d      = 0;
    for (int k = 0; k < NREQ; k++) begin
      cand_d = int'(rr_ptr_q) + k;
      if (cand_d >= NREQ) begin
        cand_d = cand_d - NREQ;
      end
      for (int j = 0; j < NREQ; j++) begin
        if (!grant_vld_d && (j == cand_d) && bus.req_ctrl_valid[j]) begin
          grant_vld_d = 1'b1;
          grant_d     = 3'(j);
        end
      end
    end
  end

  // Fields of the prospective winner, latched when leaving IDLE
  always_comb begin
    index_d  = '0;
    length_d = '0;
    size_d   = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (grant_d == 3'(j)) begin
        index_d  = bus.req_ctrl_index[j*LEN_W +: LEN_W];
        length_d = bus.req_ctrl_length[j*LEN_W +: LEN_W];
        size_d   = bus.req_ctrl_size[j*3 +: 3];
      end
    end
  end

`ifdef DMA_RD_ARB_FIXED_PRIO_EN
  assign next_ptr_d = 3'd0;
`else
  assign next_ptr_d = (owner_q == LAST_REQ) ? 3'd0 : owner_q + 3'd1;
`endif

  // Owner's channel-ready, selected for the DMA side
  always_comb begin
    owner_chnl_ready = 1'b0;
    for (int j = 0; j < NREQ; j++) begin
      if (owner_q == 3'(j)) begin
        owner_chnl_ready = bus.req_chnl_ready[j];
      end
    end
  end

  // Handshake pass-throughs are gated by state so that an asynchronous reset
  // forces them low immediately.
  for (genvar i = 0; i < NREQ; i++) begin : g_req
    assign bus.req_ctrl_ready[i] = (state_q == ST_CTRL) && (owner_q == 3'(i)) &&
                                   bus.dma_read_ctrl_ready;
    assign bus.req_chnl_valid[i] = (state_q == ST_DATA) && (owner_q == 3'(i)) &&
                                   bus.dma_read_chnl_valid;
  end

  assign bus.dma_read_chnl_ready = (state_q == ST_DATA) && owner_chnl_ready;
  assign bus.req_chnl_data       = (state_q == ST_DATA) ? bus.dma_read_chnl_data : '0;
  assign beat                    = bus.dma_read_chnl_valid && bus.dma_read_chnl_ready;

  assign bus.dma_read_ctrl_valid       = ctrl_valid_q;
  assign bus.dma_read_ctrl_data_index  = index_q;
  assign bus.dma_read_ctrl_data_length = length_q;
  assign bus.dma_read_ctrl_data_size   = size_q;
  assign owner                         = owner_q;
  assign busy                          = busy_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      rr_ptr_q     <= 3'd0;
      owner_q      <= 3'd0;
      cnt_q        <= '0;
      index_q      <= '0;
      length_q     <= '0;
      size_q       <= 3'd0;
      ctrl_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (grant_vld_d) begin
            owner_q      <= grant_d;
            index_q      <= index_d;
            length_q     <= length_d;
            size_q       <= size_d;
            ctrl_valid_q <= 1'b1;
            busy_q       <= 1'b1;
            state_q      <= ST_CTRL;
          end
        end

        ST_CTRL: begin
          if (bus.dma_read_ctrl_ready) begin
            ctrl_valid_q <= 1'b0;
            cnt_q        <= length_q;
            if (length_q == '0) begin
              // Zero-length read: nothing to stream, release the grant now
              state_q  <= ST_IDLE;
              busy_q   <= 1'b0;
              rr_ptr_q <= next_ptr_d;
            end else begin
              state_q  <= ST_DATA;
            end
          end
        end

        ST_DATA: begin
          if (beat) begin
            cnt_q <= cnt_q - LEN_W'(1);
            if (cnt_q == LEN_W'(1)) begin
              state_q  <= ST_IDLE;
              busy_q   <= 1'b0;
              rr_ptr_q <= next_ptr_d;
            end
          end
        end

        default: begin
          state_q      <= ST_IDLE;
          ctrl_valid_q <= 1'b0;
          busy_q       <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_espacc_dma_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_espacc_dma_read_arbiter
// Purpose  : Self-checking bench for espacc_dma_read_arbiter. A small
//            behavioural model (pending set + search pointer) predicts the
//            grant order and fields; the bench plays requesters and DMA.
// Config   : honours DMA_RD_ARB_FIXED_PRIO_EN in its reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_espacc_dma_read_arbiter;

  localparam int NREQ = 3;
  localparam int DW   = 32;
  localparam int LW   = 32;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] owner;
  logic       busy;

  always #5 clk = ~clk;

  espacc_dma_read_arbiter_if #(.NREQ(NREQ), .DMA_BUS_WIDTH(DW), .LEN_W(LW)) bus ();

  espacc_dma_read_arbiter #(.NREQ(NREQ), .DMA_BUS_WIDTH(DW), .LEN_W(LW)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .owner (owner),
    .busy  (busy)
  );

  int vectors    = 0;
  int miscompares = 0;

  // Reference model state
  bit          pend   [NREQ];
  logic [31:0] m_idx  [NREQ];
  logic [31:0] m_len  [NREQ];
  logic [2:0]  m_size [NREQ];
  int          rr = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] oh(input int i);
    return 64'd1 << i;
  endfunction

  // Next owner: first pending requester from the search start, with wrap
  function automatic int pick();
`ifdef DMA_RD_ARB_FIXED_PRIO_EN
    for (int k = 0; k < NREQ; k++) if (pend[k]) return k;
`else
    for (int k = 0; k < NREQ; k++) if (pend[(rr + k) % NREQ]) return (rr + k) % NREQ;
`endif
    return -1;
  endfunction

  function automatic bit any_pending();
    for (int k = 0; k < NREQ; k++) if (pend[k]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic post(input int i, input logic [31:0] idx, input logic [31:0] len,
                      input logic [2:0] sz);
    pend[i]   = 1'b1;
    m_idx[i]  = idx;
    m_len[i]  = len;
    m_size[i] = sz;
    bus.req_ctrl_valid[i]            = 1'b1;
    bus.req_ctrl_index[i*LW +: LW]   = idx;
    bus.req_ctrl_length[i*LW +: LW]  = len;
    bus.req_ctrl_size[i*3 +: 3]      = sz;
  endtask

  task automatic drop(input int i);
    pend[i] = 1'b0;
    bus.req_ctrl_valid[i]           = 1'b0;
    bus.req_ctrl_index[i*LW +: LW]  = '0;
    bus.req_ctrl_length[i*LW +: LW] = '0;
    bus.req_ctrl_size[i*3 +: 3]     = '0;
  endtask

  // One whole transaction, entered just after a falling edge with the
  // arbiter idle. mode: 0 = always ready, data 0xA0+n; 1 = owner ready low
  // for data cycles 1..5; 2 = random valid/ready/data.
  task automatic run_txn(input int stall, input int mode, input bit repost, input int abort_at);
    int          o, idle, got, cyc;
    logic [31:0] e_idx, e_len, dat;
    logic [2:0]  e_sz;
    logic        v, r;
    o = pick();
    if (o < 0) o = 0;
    e_idx = m_idx[o];
    e_len = m_len[o];
    e_sz  = m_size[o];

    bus.dma_read_ctrl_ready = 1'b0;
    bus.dma_read_chnl_valid = 1'b1;
    bus.dma_read_chnl_data  = 32'hDEAD_BEEF;
    bus.req_chnl_ready      = '1;
    #1;
    idle = 0;
    while (bus.dma_read_ctrl_valid !== 1'b1 && idle < 16) begin
      chk("idle_busy", 64'(busy), 64'd0);
      chk("idle_chnl_valid", 64'(bus.req_chnl_valid), 64'd0);
      chk("idle_chnl_ready", 64'(bus.dma_read_chnl_ready), 64'd0);
      chk("idle_ctrl_ready", 64'(bus.req_ctrl_ready), 64'd0);
      @(negedge clk); #1;
      idle++;
    end
    chk("grant_latency", 64'(idle), 64'd1);
    chk("grant_owner", 64'(owner), 64'(o));
    chk("grant_busy", 64'(busy), 64'd1);

    for (int s = 0; s <= stall; s++) begin
      if (s == stall) begin
        bus.dma_read_ctrl_ready = 1'b1;
        #1;
      end
      chk("ctrl_valid", 64'(bus.dma_read_ctrl_valid), 64'd1);
      chk("ctrl_index", 64'(bus.dma_read_ctrl_data_index), 64'(e_idx));
      chk("ctrl_length", 64'(bus.dma_read_ctrl_data_length), 64'(e_len));
      chk("ctrl_size", 64'(bus.dma_read_ctrl_data_size), 64'(e_sz));
      chk("ctrl_chnl_valid", 64'(bus.req_chnl_valid), 64'd0);
      chk("ctrl_chnl_ready", 64'(bus.dma_read_chnl_ready), 64'd0);
      chk("req_ctrl_ready", 64'(bus.req_ctrl_ready), (s == stall) ? oh(o) : 64'd0);
      @(negedge clk);
      if (s != stall) #1;
    end
    bus.dma_read_ctrl_ready = 1'b0;
    if (repost) post(o, e_idx, e_len, e_sz);
    else        drop(o);

    got = 0;
    cyc = 0;
    while (got < e_len && cyc < 200) begin
      if (got == abort_at) begin
        bus.dma_read_chnl_valid = 1'b1;
        bus.req_chnl_ready      = '1;
        rst = 1'b0;
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_owner", 64'(owner), 64'd0);
        chk("rst_ctrl_valid", 64'(bus.dma_read_ctrl_valid), 64'd0);
        chk("rst_ctrl_index", 64'(bus.dma_read_ctrl_data_index), 64'd0);
        chk("rst_ctrl_length", 64'(bus.dma_read_ctrl_data_length), 64'd0);
        chk("rst_chnl_valid", 64'(bus.req_chnl_valid), 64'd0);
        chk("rst_chnl_ready", 64'(bus.dma_read_chnl_ready), 64'd0);
        chk("rst_chnl_data", 64'(bus.req_chnl_data), 64'd0);
        return;
      end
      case (mode)
        0: begin v = 1'b1; r = 1'b1; dat = 32'hA0 + 32'(got); end
        1: begin v = 1'b1; r = !(cyc >= 1 && cyc <= 5); dat = 32'hA0 + 32'(got); end
        default: begin
          v   = ($urandom_range(0, 3) != 0);
          r   = ($urandom_range(0, 3) != 0);
          dat = $urandom;
        end
      endcase
      bus.dma_read_chnl_valid = v;
      bus.dma_read_chnl_data  = dat;
      bus.req_chnl_ready      = NREQ'($urandom);
      bus.req_chnl_ready[o]   = r;
      #1;
      chk("data_busy", 64'(busy), 64'd1);
      chk("data_chnl_valid", 64'(bus.req_chnl_valid), v ? oh(o) : 64'd0);
      chk("data_chnl_ready", 64'(bus.dma_read_chnl_ready), 64'(r));
      if (v) chk("data_chnl_data", 64'(bus.req_chnl_data), 64'(dat));
      chk("data_ctrl_ready", 64'(bus.req_ctrl_ready), 64'd0);
      if (v && r) got++;
      cyc++;
      @(negedge clk);
    end
    chk("beats_done", 64'(got), 64'(e_len));
    #1;
    chk("end_busy", 64'(busy), 64'd0);
    chk("end_chnl_ready", 64'(bus.dma_read_chnl_ready), 64'd0);
    rr = (o + 1) % NREQ;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state, with every input asserted to expose leaks
    bus.req_ctrl_valid      = '1;
    bus.req_ctrl_index      = '1;
    bus.req_ctrl_length     = '1;
    bus.req_ctrl_size       = '1;
    bus.req_chnl_ready      = '1;
    bus.dma_read_ctrl_ready = 1'b1;
    bus.dma_read_chnl_valid = 1'b1;
    bus.dma_read_chnl_data  = 32'h1234_5678;
    for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_owner", 64'(owner), 64'd0);
    chk("reset_ctrl_valid", 64'(bus.dma_read_ctrl_valid), 64'd0);
    chk("reset_ctrl_index", 64'(bus.dma_read_ctrl_data_index), 64'd0);
    chk("reset_ctrl_length", 64'(bus.dma_read_ctrl_data_length), 64'd0);
    chk("reset_ctrl_size", 64'(bus.dma_read_ctrl_data_size), 64'd0);
    chk("reset_ctrl_ready", 64'(bus.req_ctrl_ready), 64'd0);
    chk("reset_chnl_valid", 64'(bus.req_chnl_valid), 64'd0);
    chk("reset_chnl_ready", 64'(bus.dma_read_chnl_ready), 64'd0);
    chk("reset_chnl_data", 64'(bus.req_chnl_data), 64'd0);
    for (int i = 0; i < NREQ; i++) drop(i);
    bus.dma_read_ctrl_ready = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Single request
    post(0, 32'h100, 32'd4, 3'd2);
    run_txn(0, 0, 1'b0, -1);

    // Contention between requesters 0 and 1, both held
    post(0, 32'h200, 32'd2, 3'd2);
    post(1, 32'h300, 32'd2, 3'd1);
    run_txn(0, 0, 1'b1, -1);
    run_txn(0, 0, 1'b1, -1);
    run_txn(0, 0, 1'b0, -1);
    run_txn(0, 0, 1'b0, -1);

    // Backpressure on requester 1
    post(1, 32'h400, 32'd3, 3'd2);
    run_txn(0, 1, 1'b0, -1);

    // Zero length with requester 1 pending
    post(0, 32'h500, 32'd0, 3'd2);
    post(1, 32'h600, 32'd2, 3'd2);
    run_txn(0, 0, 1'b0, -1);
    run_txn(0, 0, 1'b0, -1);

    // DMA ctrl stall on the top requester
    post(NREQ - 1, 32'h700, 32'd1, 3'd3);
    run_txn(10, 0, 1'b0, -1);

    // Randomized traffic
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && $urandom_range(0, 1) == 1)
          post(i, $urandom, 32'($urandom_range(0, 6)), 3'($urandom_range(0, 7)));
      end
      if (!any_pending())
        post(int'($urandom_range(0, NREQ - 1)), $urandom, 32'($urandom_range(0, 6)),
             3'($urandom_range(0, 7)));
      run_txn(int'($urandom_range(0, 3)), 2, 1'b0, -1);
    end
    for (int t = 0; t < NREQ; t++) begin
      if (any_pending()) run_txn(0, 2, 1'b0, -1);
    end

    // Reset mid-DATA, then a fresh grant
    post(0, 32'h800, 32'd8, 3'd2);
    run_txn(0, 0, 1'b0, 2);
    @(negedge clk);
    for (int i = 0; i < NREQ; i++) drop(i);
    rr = 0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    post(1, 32'h900, 32'd2, 3'd2);
    run_txn(0, 0, 1'b0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
